// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with stall,
// halt/resume, program counter and retired-instruction counter.
module multicycle_controller #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] instr,
    input  logic              dec_load,
    input  logic              dec_store,
    input  logic              dec_branch,
    input  logic              dec_halt,
    input  logic              dec_write_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              branch_taken,
    output logic [DATA_W-1:0] alu_q,
    output logic [DATA_W-1:0] mem_data,
    output logic              reg_we,
    output logic              wb_sel,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        phase,
    output logic              halted,
    input  logic              resume,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t            state;
    logic              retire;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;

    always_comb begin
        retire = 1'b0;
        unique case (state)
            S_EXECUTE: retire = ~(dec_load | dec_store) & ~dec_write_reg;
            S_MEM:     retire = mem_ready & ~dec_load;
            S_WB:      retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    // Retiring straight out of EXECUTE must use the value being latched now.
    assign target  = (state == S_EXECUTE) ? alu_result[ADDR_W-1:0]
                                          : alu_q[ADDR_W-1:0];
    assign next_pc = (dec_branch & branch_taken) ? target
                                                 : pc + ADDR_W'(1);

    assign mem_req  = rst & ((state == S_FETCH) | (state == S_MEM));
    assign mem_we   = rst & (state == S_MEM) & dec_store & ~dec_load;
    assign mem_addr = (state == S_MEM) ? alu_q[ADDR_W-1:0] : pc;
    assign reg_we   = rst & (state == S_WB) & dec_write_reg;
    assign wb_sel   = dec_load;
    assign halted   = rst & (state == S_HALT);
    assign phase    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            instr    <= '0;
            alu_q    <= '0;
            mem_data <= '0;
            retired  <= '0;
        end else begin
            if (retire) begin
                pc      <= next_pc;
                retired <= retired + CNT_W'(1);
            end
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        instr <= mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= dec_halt ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_q <= alu_result;
                    if (dec_load | dec_store)
                        state <= S_MEM;
                    else if (dec_write_reg)
                        state <= S_WB;
                    else
                        state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (dec_load) begin
                            mem_data <= mem_rdata;
                            state    <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (resume) begin
                        pc      <= pc + ADDR_W'(1);
                        retired <= retired + CNT_W'(1);
                        state   <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle sequencer; next generation of the core's phase controller and program counter.
- Replaces the single instr_phase toggle with a FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT state machine.
- Adds a ready handshake so memory may stall, supports halt/resume, and counts retired instructions.
- Sits between the memory bus, the decoder, the ALU and the register file write port.

Parameters:
- ADDR_W, 8, memory/PC address width
- DATA_W, 64, instruction and data word width
- RESET_PC, 0, PC value on reset
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_req  out  1  access request
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  ADDR_W  access address
- instr  out  DATA_W  instruction register, feeds the decoder
- dec_load, dec_store, dec_branch, dec_halt, dec_write_reg  in  1 each  decoder flags (combinational from instr)
- alu_result  in  DATA_W  ALU output
- branch_taken  in  1  branch condition
- alu_q  out  DATA_W  ALU result latched in EXECUTE
- mem_data  out  DATA_W  latched load data
- reg_we  out  1  register-file write pulse
- wb_sel  out  1  1 = write back mem_data, 0 = write back alu_q
- pc  out  ADDR_W  program counter
- phase  out  3  state encoding
- halted  out  1  core in HALT
- resume  in  1  leave HALT
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc=RESET_PC; instr, alu_q, mem_data and retired all 0.
  - mem_req, mem_we, reg_we and halted are forced 0 while rst=0 (gated by rst).
  - Reset mid-access abandons the access: mem_req drops in the same instant.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Hold until mem_ready=1; on that edge instr<=mem_rdata, go to DECODE.
- DECODE: single cycle; dec_halt -> HALT, else -> EXECUTE.
- EXECUTE: single cycle; alu_q<=alu_result.
  - dec_load or dec_store -> MEM.
  - else dec_write_reg -> WRITEBACK.
  - else -> FETCH (retire).
- MEM:
  - mem_req=1, mem_addr=alu_q[ADDR_W-1:0], mem_we=dec_store & ~dec_load (load wins if both flags are set).
  - Hold until mem_ready.
  - Load: mem_data<=mem_rdata, go to WRITEBACK.
  - Store: go to FETCH (retire).
- WRITEBACK: reg_we=dec_write_reg for exactly this one cycle, wb_sel=dec_load; go to FETCH (retire).
- Handshake rules:
  - mem_addr and mem_we stay stable while mem_req=1 and mem_ready=0.
  - mem_ready is ignored in DECODE, EXECUTE, WRITEBACK and HALT.
  - No cycle limit on a stall.
- Retire (every transition into FETCH from EXECUTE, MEM or WRITEBACK):
  - pc <= (dec_branch & branch_taken) ? alu_q[ADDR_W-1:0] : pc+1, with pc+1 wrapping mod 2^ADDR_W.
  - retired <= retired+1, wrapping mod 2^CNT_W.
  - A branch with dec_write_reg set still writes back (link) before the PC update.
- HALT:
  - halted=1; pc holds at the halt instruction; no memory requests.
  - resume=1 -> pc<=pc+1, retired+1, go to FETCH.
  - resume held high while entering HALT has no effect until the cycle after entry.
- instr, alu_q and mem_data change only in the states listed above; otherwise they hold.

Test Plan:
- Reset then release with mem_ready=1 constant and an ALU instruction with write_reg -> phases 0,1,2,4,0; reg_we pulses once with wb_sel=0; pc 0->1; retired=1.
- Load, alu_result=0x20, mem_ready asserted 3 cycles after the MEM request -> mem_addr=0x20 held for 3 cycles, mem_data=mem_rdata, reg_we with wb_sel=1; instruction takes 8 cycles.
- Store, alu_result=0x41 -> one MEM cycle with mem_we=1 and addr 0x41, no reg_we, pc+1.
- Taken branch at pc=0x10 with alu_result=0x05 -> pc=0x05; not-taken -> 0x11; pc=0xFF not-taken -> wraps to 0x00.
- Halt instruction at pc=3 -> halted=1, phase=5, pc stays 3 and mem_req=0 for 10 cycles; pulse resume -> FETCH at pc=4, retired increments by 1.
- Assert rst low during a stalled FETCH -> mem_req=0 immediately; after release pc=RESET_PC, retired=0, phase=0.
